// File: rtl/fb_pkg.sv
// Shared constants and types for the 1-bpp framebuffer writer.
package fb_pkg;
  localparam int FB_WORDS = 9600;  // 640x480 pixels / 32 pixels per word
  localparam int ADDR_W   = 15;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_WORDCNT = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_FILL_GO  = 1;
  localparam int CTRL_FILL_VAL = 2;

  localparam int ST_BUSY       = 0;
  localparam int ST_FRAME_DONE = 1;
  localparam int ST_SOF_ERR    = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FILL   = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_writer_if.sv
// Register bus, pixel stream and framebuffer write port of fb_writer.
interface fb_writer_if #(
  parameter int ADDR_W = fb_pkg::ADDR_W
) ();
  logic              chipselect;
  logic              write;
  logic              read;
  logic [1:0]        address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              pix_data;
  logic              pix_valid;
  logic              pix_sof;
  logic              pix_ready;
  logic [ADDR_W-1:0] fb_address;
  logic [31:0]       fb_writedata;
  logic              fb_write;

  modport slave (
    input  chipselect, write, read, address, writedata,
    input  pix_data, pix_valid, pix_sof,
    output readdata, pix_ready, fb_address, fb_writedata, fb_write
  );

  modport master (
    output chipselect, write, read, address, writedata,
    output pix_data, pix_valid, pix_sof,
    input  readdata, pix_ready, fb_address, fb_writedata, fb_write
  );
endinterface

// File: rtl/fb_pix_packer.sv
// Packs accepted 1-bit pixels LSB-first into 32-bit words.
module fb_pix_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        pix,
  input  logic        sof,
  input  logic        clear,
  output logic [4:0]  bitcnt,
  output logic        word_done,
  output logic [31:0] word
);
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [31:0] asm_q, asm_d;

  // Drop each pixel into its bit slot; the 32nd pixel completes the word.
  always_comb begin
    bitcnt_d  = bitcnt_q;
    asm_d     = asm_q;
    word      = asm_q;
    word_done = 1'b0;
    if (accept) begin
      if (sof) begin
        asm_d    = {31'b0, pix};
        bitcnt_d = 5'd1;
      end else begin
        asm_d[bitcnt_q] = pix;
        word            = asm_d;
        if (bitcnt_q == 5'd31) begin
          word_done = 1'b1;
          asm_d     = '0;
        end
        bitcnt_d = bitcnt_q + 5'd1;
      end
    end
    // A completed word still reports word_done; only the partial is lost.
    if (clear) begin
      bitcnt_d = '0;
      asm_d    = '0;
    end
  end

  // Assembly register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt_q <= '0;
      asm_q    <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      asm_q    <= asm_d;
    end
  end

  assign bitcnt = bitcnt_q;
endmodule

// File: rtl/fb_writer.sv
// 1-bpp framebuffer writer: pixel stream packing, clear/fill engine, CSRs.
module fb_writer #(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int ADDR_W   = fb_pkg::ADDR_W
) (
  input logic        clk,
  input logic        reset,
  fb_writer_if.slave bus
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);

  fb_state_e         state_q, state_d;
  logic              en_q, en_d;
  logic              fill_val_q, fill_val_d;
  logic              fill_word_q, fill_word_d;
  logic              frame_done_q, frame_done_d;
  logic              sof_err_q, sof_err_d;
  logic [ADDR_W-1:0] wordcnt_q, wordcnt_d;
  logic              fb_write_q, fb_write_d;
  logic [ADDR_W-1:0] fb_address_q, fb_address_d;
  logic [31:0]       fb_writedata_q, fb_writedata_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              reg_wr, ctrl_wr, status_wr, fill_go, accept;
  logic              frame_set, sof_set, pk_clear, pk_done;
  logic [4:0]        pk_bitcnt;
  logic [31:0]       pk_word;

  assign reg_wr    = bus.chipselect & bus.write;
  assign ctrl_wr   = reg_wr && (bus.address == REG_CTRL);
  assign status_wr = reg_wr && (bus.address == REG_STATUS);
  assign fill_go   = ctrl_wr && bus.writedata[CTRL_FILL_GO];
  assign accept    = bus.pix_valid && (state_q == S_STREAM);

  fb_pix_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .pix       (bus.pix_data),
    .sof       (bus.pix_sof),
    .clear     (pk_clear),
    .bitcnt    (pk_bitcnt),
    .word_done (pk_done),
    .word      (pk_word)
  );

  // Mode FSM plus word counter and framebuffer write port.
  always_comb begin
    state_d        = state_q;
    wordcnt_d      = wordcnt_q;
    fill_word_d    = fill_word_q;
    fb_write_d     = 1'b0;
    fb_address_d   = fb_address_q;
    fb_writedata_d = fb_writedata_q;
    frame_set      = 1'b0;
    sof_set        = 1'b0;
    pk_clear       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_go) begin
          state_d     = S_FILL;
          wordcnt_d   = '0;
          fill_word_d = bus.writedata[CTRL_FILL_VAL];
        end else if (en_q) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept && bus.pix_sof) begin
          sof_set   = (pk_bitcnt != 5'd0) || (wordcnt_q != '0);
          wordcnt_d = '0;
        end
        if (pk_done) begin
          fb_write_d     = 1'b1;
          fb_address_d   = wordcnt_q;
          fb_writedata_d = pk_word;
          if (wordcnt_q == LAST_WORD) begin
            wordcnt_d = '0;
            frame_set = 1'b1;
          end else begin
            wordcnt_d = wordcnt_q + 1'b1;
          end
        end
        // Leaving the stream drops the partial word and restarts counting.
        if (fill_go) begin
          state_d     = S_FILL;
          wordcnt_d   = '0;
          pk_clear    = 1'b1;
          fill_word_d = bus.writedata[CTRL_FILL_VAL];
        end else if (!en_q) begin
          state_d   = S_IDLE;
          wordcnt_d = '0;
          pk_clear  = 1'b1;
        end
      end
      S_FILL: begin
        fb_write_d     = 1'b1;
        fb_address_d   = wordcnt_q;
        fb_writedata_d = {32{fill_word_q}};
        if (wordcnt_q == LAST_WORD) begin
          wordcnt_d = '0;
          frame_set = 1'b1;
          state_d   = en_q ? S_STREAM : S_IDLE;
        end else begin
          wordcnt_d = wordcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control/status registers and registered read mux; set beats W1C.
  always_comb begin
    en_d         = en_q;
    fill_val_d   = fill_val_q;
    frame_done_d = frame_done_q;
    sof_err_d    = sof_err_q;
    readdata_d   = readdata_q;
    if (ctrl_wr) begin
      en_d       = bus.writedata[CTRL_EN];
      fill_val_d = bus.writedata[CTRL_FILL_VAL];
    end
    if (status_wr && bus.writedata[ST_FRAME_DONE]) frame_done_d = 1'b0;
    if (status_wr && bus.writedata[ST_SOF_ERR])    sof_err_d    = 1'b0;
    if (frame_set) frame_done_d = 1'b1;
    if (sof_set)   sof_err_d    = 1'b1;
    if (bus.chipselect && bus.read) begin
      readdata_d = '0;
      case (bus.address)
        REG_CTRL: begin
          readdata_d[CTRL_EN]       = en_q;
          readdata_d[CTRL_FILL_VAL] = fill_val_q;
        end
        REG_STATUS: begin
          readdata_d[ST_BUSY]       = (state_q != S_IDLE);
          readdata_d[ST_FRAME_DONE] = frame_done_q;
          readdata_d[ST_SOF_ERR]    = sof_err_q;
        end
        REG_WORDCNT: readdata_d = 32'(wordcnt_q);
        default:     readdata_d = '0;
      endcase
    end
  end

  // All state registers; reset aborts any fill or partial word at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      en_q           <= 1'b0;
      fill_val_q     <= 1'b0;
      fill_word_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      sof_err_q      <= 1'b0;
      wordcnt_q      <= '0;
      fb_write_q     <= 1'b0;
      fb_address_q   <= '0;
      fb_writedata_q <= '0;
      readdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      en_q           <= en_d;
      fill_val_q     <= fill_val_d;
      fill_word_q    <= fill_word_d;
      frame_done_q   <= frame_done_d;
      sof_err_q      <= sof_err_d;
      wordcnt_q      <= wordcnt_d;
      fb_write_q     <= fb_write_d;
      fb_address_q   <= fb_address_d;
      fb_writedata_q <= fb_writedata_d;
      readdata_q     <= readdata_d;
    end
  end

  assign bus.pix_ready    = (state_q == S_STREAM);
  assign bus.fb_write     = fb_write_q;
  assign bus.fb_address   = fb_address_q;
  assign bus.fb_writedata = fb_writedata_q;
  assign bus.readdata     = readdata_q;
endmodule

// File: tb/tb_fb_writer.sv
// Randomized bench for fb_writer with a queue-based reference model.
module tb_fb_writer;
  import fb_pkg::*;

  localparam int NW = 20;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_wr_seen = 0;

  // Reference model: pending pixels of the current word, word index, flags.
  bit          stream_on = 1'b0;
  bit          m_bits[$];
  int          m_wc = 0;
  bit          m_fd = 1'b0;
  bit          m_se = 1'b0;
  int          q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  logic [31:0] rd;

  fb_writer_if #(.ADDR_W(AW)) bus ();

  fb_writer #(.FB_WORDS(NW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.fb_write) begin
        n_wr_seen++;
        if (q_addr.size() == 0) begin
          chk("spurious_write", 32'(bus.fb_write), 32'd0);
        end else begin
          chk("wr_addr", 32'(bus.fb_address), 32'(q_addr.pop_front()));
          chk("wr_data", bus.fb_writedata, q_data.pop_front());
          chk("wr_cycle", 32'(cyc), 32'(q_cyc.pop_front()));
        end
      end
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.pix_valid  = 1'b0;
    bus.pix_sof    = 1'b0;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.pix_valid  = 1'b0;
    bus.pix_sof    = 1'b0;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d = bus.readdata;
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return {29'b0, m_se, m_fd, busy};
  endfunction

  task automatic model_accept(input bit d, input bit s);
    logic [31:0] w;
    if (s) begin
      if (m_bits.size() != 0 || m_wc != 0) m_se = 1'b1;
      m_bits.delete();
      m_wc = 0;
    end
    m_bits.push_back(d);
    if (m_bits.size() == 32) begin
      w = '0;
      for (int k = 0; k < 32; k++) w = w | (32'(m_bits[k]) << k);
      q_addr.push_back(m_wc);
      q_data.push_back(w);
      q_cyc.push_back(cyc + 1);
      m_bits.delete();
      m_wc = (m_wc + 1) % NW;
      if (m_wc == 0) m_fd = 1'b1;
    end
  endtask

  task automatic model_stop();
    stream_on = 1'b0;
    m_bits.delete();
    m_wc = 0;
  endtask

  task automatic drive_pix(input bit v, input bit d, input bit s);
    @(posedge clk); #1;
    chk("pix_ready", 32'(bus.pix_ready), 32'(stream_on));
    bus.pix_valid = v;
    bus.pix_data  = d;
    bus.pix_sof   = s;
    if (v && stream_on) model_accept(d, s);
  endtask

  task automatic start_fill(input bit val, input bit en);
    reg_wr(REG_CTRL, {29'b0, val, 1'b1, en});
    model_stop();
    for (int i = 0; i < NW; i++) begin
      q_addr.push_back(i);
      q_data.push_back({32{val}});
      q_cyc.push_back(cyc + 1 + i);
    end
  endtask

  task automatic wait_fill(input bit en_after);
    for (int i = 0; i < NW + 8 && q_addr.size() != 0; i++) begin
      @(posedge clk); #1;
      if (q_addr.size() > 1) chk("fill_pix_ready", 32'(bus.pix_ready), 32'd0);
    end
    chk("fill_timeout", 32'(q_addr.size()), 32'd0);
    m_fd = 1'b1;
    stream_on = en_after;
    m_bits.delete();
    m_wc = 0;
  endtask

  task automatic clear_status();
    reg_wr(REG_STATUS, 32'h6);
    m_fd = 1'b0;
    m_se = 1'b0;
  endtask

  initial begin
    int target;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.pix_data   = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_sof    = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    @(posedge clk); #1;
    chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    chk("rst_fb_write", 32'(bus.fb_write), 32'd0);
    chk("rst_fb_address", 32'(bus.fb_address), 32'd0);
    chk("rst_fb_writedata", bus.fb_writedata, 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    reg_rd(REG_CTRL, rd);    chk("rst_ctrl", rd, 32'd0);
    reg_rd(REG_STATUS, rd);  chk("rst_status", rd, 32'd0);
    reg_rd(REG_WORDCNT, rd); chk("rst_wordcnt", rd, 32'd0);

    // Alternating pattern word
    reg_wr(REG_CTRL, 32'h1);
    stream_on = 1'b1;
    for (int i = 0; i < 32; i++) drive_pix(1'b1, ((i % 2) == 0), 1'b0);
    drive_pix(1'b0, 1'b0, 1'b0);
    reg_rd(REG_WORDCNT, rd); chk("alt_wordcnt", rd, 32'(m_wc));
    reg_rd(REG_CTRL, rd);    chk("alt_ctrl", rd, 32'h1);
    chk("alt_missing", 32'(q_addr.size()), 32'd0);
    reg_wr(REG_CTRL, 32'h0);
    model_stop();

    // Full all-white frame starting with sof
    reg_wr(REG_CTRL, 32'h1);
    stream_on = 1'b1;
    for (int i = 0; i < NW * 32; i++) drive_pix(1'b1, 1'b1, (i == 0));
    drive_pix(1'b0, 1'b0, 1'b0);
    reg_rd(REG_STATUS, rd);  chk("frame_status", rd, exp_status(1'b1));
    reg_rd(REG_WORDCNT, rd); chk("frame_wordcnt", rd, 32'd0);
    chk("frame_missing", 32'(q_addr.size()), 32'd0);
    clear_status();

    // 40 pixels then an early sof
    for (int i = 0; i < 40; i++) drive_pix(1'b1, 1'($urandom), 1'b0);
    drive_pix(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 31; i++) drive_pix(1'b1, 1'($urandom), 1'b0);
    drive_pix(1'b0, 1'b0, 1'b0);
    reg_rd(REG_STATUS, rd); chk("sof_err_status", rd, exp_status(1'b1));
    chk("sof_missing", 32'(q_addr.size()), 32'd0);
    clear_status();

    // Randomized stream with occasional enable toggles and readbacks
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reg_wr(REG_CTRL, 32'h0);
        model_stop();
        reg_wr(REG_CTRL, 32'h1);
        stream_on = 1'b1;
      end else if (r < 4) begin
        reg_rd(REG_WORDCNT, rd); chk("rnd_wordcnt", rd, 32'(m_wc));
      end else begin
        drive_pix(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 63) == 0));
      end
    end
    drive_pix(1'b0, 1'b0, 1'b0);
    reg_rd(REG_STATUS, rd); chk("rnd_status", rd, exp_status(1'b1));
    chk("rnd_missing", 32'(q_addr.size()), 32'd0);
    reg_wr(REG_CTRL, 32'h0);
    model_stop();
    clear_status();

    // White fill; second FILL_GO ignored, EN=1 written mid-fill
    start_fill(1'b1, 1'b0);
    reg_rd(REG_STATUS, rd); chk("fill_busy", rd, exp_status(1'b1));
    reg_wr(REG_CTRL, 32'h3);
    wait_fill(1'b1);
    reg_rd(REG_STATUS, rd); chk("fill_to_stream", rd, exp_status(1'b1));
    for (int i = 0; i < 32; i++) drive_pix(1'b1, 1'($urandom), 1'b0);
    drive_pix(1'b0, 1'b0, 1'b0);
    reg_wr(REG_CTRL, 32'h0);
    model_stop();
    clear_status();

    // Black fill back to idle
    start_fill(1'b0, 1'b0);
    wait_fill(1'b0);
    reg_rd(REG_STATUS, rd); chk("fill0_status", rd, exp_status(1'b0));
    clear_status();
    reg_rd(REG_STATUS, rd); chk("w1c_clear", rd, 32'd0);

    // Clear of FRAME_DONE in the same cycle the fill completes
    start_fill(1'b1, 1'b0);
    repeat (NW - 2) @(posedge clk);
    reg_wr(REG_STATUS, 32'h2);
    wait_fill(1'b0);
    reg_rd(REG_STATUS, rd); chk("w1c_race", rd, exp_status(1'b0));
    clear_status();

    // Reset in the middle of a fill
    start_fill(1'b1, 1'b0);
    target = n_wr_seen + 10;
    for (int i = 0; i < 4 * NW && n_wr_seen < target; i++) @(negedge clk);
    chk("rst_fill_timeout", 32'(n_wr_seen >= target), 32'd1);
    #1;
    reset = 1'b1;
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    model_stop();
    m_fd = 1'b0;
    m_se = 1'b0;
    #1;
    chk("rst_mid_fb_write", 32'(bus.fb_write), 32'd0);
    chk("rst_mid_readdata", bus.readdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    reg_rd(REG_STATUS, rd);  chk("rst_mid_status", rd, 32'd0);
    reg_rd(REG_WORDCNT, rd); chk("rst_mid_wordcnt", rd, 32'd0);
    reg_rd(REG_CTRL, rd);    chk("rst_mid_ctrl", rd, 32'd0);
    repeat (NW) @(posedge clk);
    chk("rst_mid_no_writes", 32'(q_addr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FB_WORDS, default 9600, meaning number of 32-bit framebuffer words per frame (640x480 at 1 bpp).
REQ-002 Parameter ADDR_W, default 15, meaning framebuffer word-address width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 chipselect  input  1  Avalon-MM slave select for control registers.
REQ-006 write / read  input  1 each  Avalon-MM register write / read strobes.
REQ-007 address  input  2  register index: 0 CTRL, 1 STATUS, 2 WORDCNT.
REQ-008 writedata  input  32  register write data.
REQ-009 readdata  output  32  register read data, valid the cycle after read (registered).
REQ-010 pix_data  input  1  stream pixel, 1 = white, 0 = black.
REQ-011 pix_valid / pix_sof  input  1 each  pixel valid; first pixel of frame marker.
REQ-012 pix_ready  output  1  block accepts pixel this cycle.
REQ-013 fb_address  output  ADDR_W  framebuffer write word address.
REQ-014 fb_writedata  output  32  packed pixel word.
REQ-015 fb_write  output  1  one-cycle framebuffer write strobe; RAM never back-pressures.

Function
REQ-016 CTRL: bit0 EN (stream enable, R/W), bit1 FILL_GO (write-1 pulse, reads 0), bit2 FILL_VAL (R/W).
REQ-017 STATUS: bit0 BUSY (RO, state != IDLE), bit1 FRAME_DONE, bit2 SOF_ERR; bits 1-2 sticky, write-1-to-clear.
REQ-018 WORDCNT: current word counter value, zero-extended, RO.
REQ-019 FSM states IDLE, STREAM, FILL; IDLE->FILL on FILL_GO; IDLE->STREAM when EN=1; STREAM->IDLE when EN=0; STREAM->FILL on FILL_GO; FILL->(EN ? STREAM : IDLE) after last fill word.
REQ-020 pix_ready SHALL be 1 exactly in STREAM; a pixel is accepted when pix_valid && pix_ready.
REQ-021 Accepted pixel k of a word (bitcnt k, 0..31) SHALL be stored at bit k of the assembly register.
REQ-022 On acceptance of bitcnt=31, fb_write SHALL assert the next cycle with fb_address=wordcnt and fb_writedata=assembled word; wordcnt then increments.
REQ-023 wordcnt SHALL wrap FB_WORDS-1 -> 0 and set FRAME_DONE on that wrap.
REQ-024 Accepted pixel with pix_sof=1 SHALL force bitcnt=0, wordcnt=0 and be stored as bit 0 of word 0; partial assembly discarded.
REQ-025 If pix_sof accepted while bitcnt!=0 or wordcnt!=0, SOF_ERR SHALL set.
REQ-026 pix_sof without pix_valid SHALL be ignored.
REQ-027 FILL: one write per cycle, addresses 0..FB_WORDS-1 ascending, data = 32 copies of FILL_VAL latched at entry; first write the cycle after entry; FRAME_DONE set after last.
REQ-028 FILL_GO while in FILL SHALL be ignored; EN changes in FILL take effect only at exit.
REQ-029 Leaving STREAM (EN=0 or FILL_GO) SHALL discard partial word and clear bitcnt and wordcnt; a completed word pending write SHALL still be written.
REQ-030 Register write to STATUS W1C and a same-cycle set event: set wins.

Reset
REQ-031 On reset: state IDLE, CTRL=0, STATUS sticky bits 0, bitcnt=0, wordcnt=0, assembly=0.
REQ-032 Reset outputs: pix_ready=0, fb_write=0, fb_address=0, fb_writedata=0, readdata=0.
REQ-033 Reset mid-FILL or mid-word SHALL abort immediately with no further fb_write.

Structure
REQ-034 Shared package fb_pkg SHALL hold FB_WORDS, ADDR_W, register index constants, CTRL/STATUS bit positions, and the state enum type.
REQ-035 Sub-module fb_pix_packer (32-bit shift/assembly with bitcnt and word-complete pulse) SHALL be instantiated once; FSM, counters and registers remain in fb_writer.

Verification
REQ-036 EN=1, stream 32 pixels pattern 1,0,1,0... -> one fb_write, fb_address=0, fb_writedata=0x55555555, next cycle after 32nd accept.
REQ-037 EN=1, stream 640x480 all-1 pixels with sof on first -> 9600 writes of 0xFFFFFFFF, addresses 0..9599, FRAME_DONE=1, WORDCNT=0.
REQ-038 Stream 40 pixels then sof pixel -> SOF_ERR=1, next write at address 0 holding sof pixel at bit 0; no write of the 8-pixel partial.
REQ-039 FILL_VAL=1, FILL_GO -> BUSY=1, 9600 consecutive writes of 0xFFFFFFFF, pix_ready=0 throughout, then IDLE, FRAME_DONE=1.
REQ-040 Assert reset at fill word 100 -> fb_write=0 from reset onward, STATUS=0, WORDCNT=0.
REQ-041 STATUS write 0x2 same cycle FRAME_DONE sets -> FRAME_DONE reads 1.
